// File: rtl/fma_pkg.sv
// Shared definitions for the FMA special-case datapath: rounding-mode codes,
// the RISC-V canonical quiet NaN, the infinity builder and the operand-class
// record that carries one operand's detector flags through the pipeline.
package fma_pkg;

   localparam int FMA_XLEN = 32;
   localparam int FMA_EXP  = 8;
   localparam int FMA_MANT = 23;

   // RISC-V rounding-mode encodings
   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   localparam logic [FMA_XLEN-1:0] CANONICAL_NAN = 32'h7fc0_0000;

   // Per-operand classification; quiet is the mantissa MSB, only meaningful with nan.
   typedef struct packed {
      logic sign;
      logic inf;
      logic zero;
      logic nan;
      logic den;
      logic quiet;
   } opClass_t;

   function automatic logic [FMA_XLEN-1:0] makeInf(input logic sign);
      return {sign, {FMA_EXP{1'b1}}, {FMA_MANT{1'b0}}};
   endfunction

   function automatic opClass_t makeClass(input logic sign, input logic inf,
                                          input logic zero, input logic nan,
                                          input logic den, input logic quiet);
      opClass_t cls;
      cls.sign  = sign;
      cls.inf   = inf;
      cls.zero  = zero;
      cls.nan   = nan;
      cls.den   = den;
      cls.quiet = quiet;
      return cls;
   endfunction

endpackage

// File: rtl/fma_special_decode.sv
// Purpose: combinational resolution of FMA special results for R = A*B + C.
// Latency: 0 cycles (pure combinational, sits between stage-1 and stage-2 registers).
// Backpressure: none; the surrounding pipeline decides when the result is captured.
// Ports: aCls/bCls/cCls operand classes, cOp raw C operand (passthrough), rm rounding
//        mode; special/result/nv are the resolved outputs (result 0 when not special).
// Option: FMA_DENORMAL_FLUSH_EN makes a denormal operand behave as a signed zero.
import fma_pkg::*;

module fma_special_decode #(
   parameter int                   PARM_XLEN          = FMA_XLEN,
   parameter logic [PARM_XLEN-1:0] PARM_CANONICAL_NAN = CANONICAL_NAN
) (
   input  opClass_t             aCls,
   input  opClass_t             bCls,
   input  opClass_t             cCls,
   input  logic [PARM_XLEN-1:0] cOp,
   input  logic [2:0]           rm,
   output logic                 special,
   output logic [PARM_XLEN-1:0] result,
   output logic                 nv
);

   logic aZero, bZero, cZero;
   logic prodSign, prodInf, prodZero;
   logic anyNan, anySnan, infTimesZero, infCancel, zeroSign;

`ifdef FMA_DENORMAL_FLUSH_EN
   // Flush-to-zero: the sign of the denormal is kept, so it acts as a signed zero.
   assign aZero = aCls.zero | aCls.den;
   assign bZero = bCls.zero | bCls.den;
   assign cZero = cCls.zero | cCls.den;
`else
   assign aZero = aCls.zero;
   assign bZero = bCls.zero;
   assign cZero = cCls.zero;
`endif

   assign prodSign = aCls.sign ^ bCls.sign;
   assign prodInf  = aCls.inf | bCls.inf;
   assign prodZero = aZero | bZero;

   assign anyNan  = aCls.nan | bCls.nan | cCls.nan;
   assign anySnan = (aCls.nan & ~aCls.quiet) | (bCls.nan & ~bCls.quiet)
                  | (cCls.nan & ~cCls.quiet);

   assign infTimesZero = (aCls.inf & bZero) | (bCls.inf & aZero);
   // Inf - Inf: opposite-signed infinities meet in the addition
   assign infCancel    = prodInf & cCls.inf & (prodSign != cCls.sign);

   // Exact zero sum: like signs keep the sign, unlike signs give -0 only under RDN
   assign zeroSign = (prodSign == cCls.sign) ? prodSign : (rm == RM_RDN);

   always_comb begin
      special = 1'b0;
      result  = '0;
      nv      = 1'b0;
      if (anyNan) begin
         special = 1'b1;
         result  = PARM_CANONICAL_NAN;
         nv      = anySnan;
      end else if (infTimesZero || infCancel) begin
         special = 1'b1;
         result  = PARM_CANONICAL_NAN;
         nv      = 1'b1;
      end else if (prodInf) begin
         special = 1'b1;
         result  = PARM_XLEN'(makeInf(prodSign));
      end else if (cCls.inf) begin
         special = 1'b1;
         result  = PARM_XLEN'(makeInf(cCls.sign));
      end else if (prodZero && cZero) begin
         special = 1'b1;
         result  = {zeroSign, {(PARM_XLEN-1){1'b0}}};
      end else if (prodZero) begin
         // C is finite and nonzero here: the sum is exactly C
         special = 1'b1;
         result  = cOp;
      end
   end

endmodule

// File: rtl/fma_special_case_handler.sv
// Purpose: two-stage pipeline resolving FMA special results and sticky invalid flag.
// Latency: 2 cycles from accepted input to valid_o, 1 set per cycle throughput.
// Backpressure: elastic valid/ready; ready_o is combinational from ready_i, no skid buffer.
// Ports: clk_i/rst_n_i (sync, active-low); valid_i/ready_o input handshake with A_i/B_i/C_i,
//        per-operand Inf/Zero/NaN/DeN flags and rm_i; valid_o/ready_i output handshake with
//        special_o/result_o/nv_o; nv_sticky_o accumulates nv_o transfers, nv_clear_i clears it.
// Option: FMA_DENORMAL_FLUSH_EN (see fma_special_decode) flushes denormal operands to zero.
import fma_pkg::*;

module fma_special_case_handler #(
   parameter int                   PARM_XLEN          = 32,
   parameter int                   PARM_EXP           = 8,
   parameter int                   PARM_MANT          = 23,
   parameter logic [PARM_XLEN-1:0] PARM_CANONICAL_NAN = 32'h7fc0_0000
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [PARM_XLEN-1:0] A_i,
   input  logic [PARM_XLEN-1:0] B_i,
   input  logic [PARM_XLEN-1:0] C_i,
   input  logic                 A_Inf_i,
   input  logic                 B_Inf_i,
   input  logic                 C_Inf_i,
   input  logic                 A_Zero_i,
   input  logic                 B_Zero_i,
   input  logic                 C_Zero_i,
   input  logic                 A_NaN_i,
   input  logic                 B_NaN_i,
   input  logic                 C_NaN_i,
   input  logic                 A_DeN_i,
   input  logic                 B_DeN_i,
   input  logic                 C_DeN_i,
   input  logic [2:0]           rm_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 special_o,
   output logic [PARM_XLEN-1:0] result_o,
   output logic                 nv_o,
   output logic                 nv_sticky_o,
   input  logic                 nv_clear_i
);

   localparam int SIGN_BIT  = PARM_EXP + PARM_MANT;
   localparam int QUIET_BIT = PARM_MANT - 1;

   opClass_t             inACls, inBCls, inCCls;
   opClass_t             s1ACls, s1BCls, s1CCls;
   logic [PARM_XLEN-1:0] s1C;
   logic [2:0]           s1Rm;
   logic                 s1Valid;
   logic                 s1Adv, s2Free, inAccept;
   logic                 decSpecial, decNv;
   logic [PARM_XLEN-1:0] decResult;

   assign inACls = makeClass(A_i[SIGN_BIT], A_Inf_i, A_Zero_i, A_NaN_i, A_DeN_i, A_i[QUIET_BIT]);
   assign inBCls = makeClass(B_i[SIGN_BIT], B_Inf_i, B_Zero_i, B_NaN_i, B_DeN_i, B_i[QUIET_BIT]);
   assign inCCls = makeClass(C_i[SIGN_BIT], C_Inf_i, C_Zero_i, C_NaN_i, C_DeN_i, C_i[QUIET_BIT]);

   // Stage 2 can take new data when empty or when its content leaves this cycle
   assign s2Free   = ~valid_o | ready_i;
   assign s1Adv    = s1Valid & s2Free;
   assign ready_o  = ~s1Valid | s1Adv;
   assign inAccept = valid_i & ready_o;

   // Stage 1: operand classes, C and rounding mode
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         s1Valid <= 1'b0;
      end else if (inAccept) begin
         s1Valid <= 1'b1;
      end else if (s1Adv) begin
         s1Valid <= 1'b0;
      end
   end

   // Payload needs no reset; it is qualified by s1Valid
   always_ff @(posedge clk_i) begin
      if (inAccept) begin
         s1ACls <= inACls;
         s1BCls <= inBCls;
         s1CCls <= inCCls;
         s1C    <= C_i;
         s1Rm   <= rm_i;
      end
   end

   fma_special_decode #(
      .PARM_XLEN          (PARM_XLEN),
      .PARM_CANONICAL_NAN (PARM_CANONICAL_NAN)
   ) uDecode (
      .aCls    (s1ACls),
      .bCls    (s1BCls),
      .cCls    (s1CCls),
      .cOp     (s1C),
      .rm      (s1Rm),
      .special (decSpecial),
      .result  (decResult),
      .nv      (decNv)
   );

   // Stage 2: outputs hold while stalled (s2Free low)
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         valid_o   <= 1'b0;
         special_o <= 1'b0;
         result_o  <= '0;
         nv_o      <= 1'b0;
      end else if (s2Free) begin
         valid_o <= s1Valid;
         if (s1Valid) begin
            special_o <= decSpecial;
            result_o  <= decResult;
            nv_o      <= decNv;
         end
      end
   end

   // Only completed transfers count; a set in the same cycle beats a clear
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         nv_sticky_o <= 1'b0;
      end else if (valid_o && ready_i && nv_o) begin
         nv_sticky_o <= 1'b1;
      end else if (nv_clear_i) begin
         nv_sticky_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fma_special_case_handler.sv
module tb_fma_special_case_handler;

   localparam logic [31:0] QNAN = 32'h7fc0_0000;
   localparam logic [2:0]  RNE  = 3'b000;
   localparam logic [2:0]  RDN  = 3'b010;
`ifdef FMA_DENORMAL_FLUSH_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        valid_i, ready_o, ready_i;
   logic [31:0] A_i, B_i, C_i;
   logic        A_Inf_i, B_Inf_i, C_Inf_i, A_Zero_i, B_Zero_i, C_Zero_i;
   logic        A_NaN_i, B_NaN_i, C_NaN_i, A_DeN_i, B_DeN_i, C_DeN_i;
   logic [2:0]  rm_i;
   logic        valid_o, special_o, nv_o, nv_sticky_o, nv_clear_i;
   logic [31:0] result_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   fma_special_case_handler dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
      .A_i(A_i), .B_i(B_i), .C_i(C_i),
      .A_Inf_i(A_Inf_i), .B_Inf_i(B_Inf_i), .C_Inf_i(C_Inf_i),
      .A_Zero_i(A_Zero_i), .B_Zero_i(B_Zero_i), .C_Zero_i(C_Zero_i),
      .A_NaN_i(A_NaN_i), .B_NaN_i(B_NaN_i), .C_NaN_i(C_NaN_i),
      .A_DeN_i(A_DeN_i), .B_DeN_i(B_DeN_i), .C_DeN_i(C_DeN_i),
      .rm_i(rm_i), .valid_o(valid_o), .ready_i(ready_i), .special_o(special_o),
      .result_o(result_o), .nv_o(nv_o), .nv_sticky_o(nv_sticky_o), .nv_clear_i(nv_clear_i)
   );

   // IEEE-754 single classification from the encoding itself
   function automatic bit isInf(input logic [31:0] x);
      return x[30:23] == 8'hff && x[22:0] == 0;
   endfunction
   function automatic bit isNan(input logic [31:0] x);
      return x[30:23] == 8'hff && x[22:0] != 0;
   endfunction
   function automatic bit isZero(input logic [31:0] x);
      return x[30:0] == 0;
   endfunction
   function automatic bit isDen(input logic [31:0] x);
      return x[30:23] == 0 && x[22:0] != 0;
   endfunction
   function automatic bit isSnan(input logic [31:0] x);
      return isNan(x) && !x[22];
   endfunction

   // Reference: {special, nv, result}, straight from the IEEE/RISC-V special-value rules
   function automatic logic [33:0] refModel(input logic [31:0] a, b, c, input logic [2:0] rm);
      bit az, bz, cz, pInf, pZero, ps, zs;
      az = isZero(a) || (FLUSH && isDen(a));
      bz = isZero(b) || (FLUSH && isDen(b));
      cz = isZero(c) || (FLUSH && isDen(c));
      ps = a[31] ^ b[31];
      pInf  = isInf(a) || isInf(b);
      pZero = az || bz;
      if (isNan(a) || isNan(b) || isNan(c))
         return {1'b1, 1'(isSnan(a) || isSnan(b) || isSnan(c)), QNAN};
      if ((isInf(a) && bz) || (isInf(b) && az)) return {2'b11, QNAN};
      if (pInf && isInf(c) && ps != c[31])      return {2'b11, QNAN};
      if (pInf)      return {2'b10, ps, 8'hff, 23'd0};
      if (isInf(c))  return {2'b10, c[31], 8'hff, 23'd0};
      if (pZero && cz) begin
         zs = (ps == c[31]) ? ps : (rm == RDN);
         return {2'b10, zs, 31'd0};
      end
      if (pZero) return {2'b10, c};
      return 34'd0;
   endfunction

   task automatic driveSet(input logic [31:0] a, b, c, input logic [2:0] rm);
      A_i = a; B_i = b; C_i = c; rm_i = rm;
      A_Inf_i = isInf(a);   B_Inf_i = isInf(b);   C_Inf_i = isInf(c);
      A_Zero_i = isZero(a); B_Zero_i = isZero(b); C_Zero_i = isZero(c);
      A_NaN_i = isNan(a);   B_NaN_i = isNan(b);   C_NaN_i = isNan(c);
      A_DeN_i = isDen(a);   B_DeN_i = isDen(b);   C_DeN_i = isDen(c);
   endtask

   function automatic logic [31:0] pickOperand();
      logic [31:0] x;
      case ($urandom_range(0, 9))
         0:       x = 32'h0000_0000;
         1:       x = 32'h7f80_0000;
         2:       x = 32'h7fc0_0000 | ($urandom & 32'h003f_ffff);
         3:       x = 32'h7f80_0000 | 32'($urandom_range(1, 32'h3f_ffff));
         4:       x = 32'h3f80_0000;
         5:       x = 32'($urandom_range(1, 32'h7f_ffff));
         6:       x = 32'h4000_0000;
         default: x = $urandom;
      endcase
      x[31] = 1'($urandom_range(0, 1));
      return x;
   endfunction

   // One isolated operation with ready_i=1; reports outputs, edge latency, sticky after transfer
   task automatic runOne(input logic [31:0] a, b, c, input logic [2:0] rm,
                         output logic [33:0] obs, output int lat, output logic sticky);
      @(negedge clk_i);
      driveSet(a, b, c, rm);
      valid_i = 1'b1; ready_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      lat = 1;
      while (!valid_o && lat < 10) begin
         @(posedge clk_i); #1;
         lat++;
      end
      if (!valid_o) lat = -1;
      obs = {special_o, nv_o, result_o};
      @(posedge clk_i); #1;
      sticky = nv_sticky_o;
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; nv_clear_i = 1'b0;
      driveSet(32'h0, 32'h0, 32'h0, RNE);
      repeat (3) @(posedge clk_i);
      @(negedge clk_i); rst_n_i = 1'b1;
      #1;
      checks++; if (valid_o !== 1'b0)      begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
      checks++; if (special_o !== 1'b0)    begin failures++; $display("FAIL reset_special got=%b exp=0", special_o); end
      checks++; if (result_o !== 32'h0)    begin failures++; $display("FAIL reset_result got=%h exp=0", result_o); end
      checks++; if (nv_o !== 1'b0)         begin failures++; $display("FAIL reset_nv got=%b exp=0", nv_o); end
      checks++; if (nv_sticky_o !== 1'b0)  begin failures++; $display("FAIL reset_sticky got=%b exp=0", nv_sticky_o); end
      checks++; if (ready_o !== 1'b1)      begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
   endtask

   task automatic test_inf_times_zero();
      logic [33:0] obs; int lat; logic st;
      runOne(32'h7f80_0000, 32'h0000_0000, 32'h3f80_0000, RNE, obs, lat, st);
      checks++; if (lat !== 2) begin failures++; $display("FAIL inf0_latency got=%0d exp=2", lat); end
      checks++; if (obs !== {2'b11, QNAN}) begin failures++; $display("FAIL inf0_result got=%h exp=%h", obs, {2'b11, QNAN}); end
      checks++; if (st !== 1'b1) begin failures++; $display("FAIL inf0_sticky got=%b exp=1", st); end
   endtask

   task automatic test_sticky();
      logic [33:0] obs; int lat; logic st;
      @(negedge clk_i); nv_clear_i = 1'b1;
      @(negedge clk_i); nv_clear_i = 1'b0;
      #1;
      checks++; if (nv_sticky_o !== 1'b0) begin failures++; $display("FAIL sticky_clear got=%b exp=0", nv_sticky_o); end
      // clear held across the nv transfer: set must win
      nv_clear_i = 1'b1;
      runOne(32'h0000_0000, 32'hff80_0000, 32'h3f80_0000, RNE, obs, lat, st);
      nv_clear_i = 1'b0;
      checks++; if (st !== 1'b1) begin failures++; $display("FAIL sticky_set_wins got=%b exp=1", st); end
   endtask

   task automatic test_inf_add();
      logic [33:0] obs; int lat; logic st;
      runOne(32'h7f80_0000, 32'h3f80_0000, 32'hff80_0000, RNE, obs, lat, st);
      checks++; if (obs !== {2'b11, QNAN}) begin failures++; $display("FAIL inf_cancel got=%h exp=%h", obs, {2'b11, QNAN}); end
      runOne(32'h7f80_0000, 32'h3f80_0000, 32'h7f80_0000, RNE, obs, lat, st);
      checks++; if (obs !== {2'b10, 32'h7f80_0000}) begin failures++; $display("FAIL inf_same got=%h exp=%h", obs, {2'b10, 32'h7f80_0000}); end
   endtask

   task automatic test_zero_signs();
      logic [33:0] obs; int lat; logic st;
      logic [31:0] cv [4] = '{32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
      logic [2:0]  rv [4] = '{RNE, RDN, RNE, RDN};
      logic [31:0] ev [4] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
      for (int i = 0; i < 4; i++) begin
         runOne(32'h8000_0000, 32'h3f80_0000, cv[i], rv[i], obs, lat, st);
         checks++;
         if (obs !== {2'b10, ev[i]}) begin
            failures++; $display("FAIL zero_sign_%0d got=%h exp=%h", i, obs, {2'b10, ev[i]});
         end
      end
   endtask

   task automatic test_nan();
      logic [33:0] obs; int lat; logic st;
      runOne(32'h7f80_0001, 32'h3f80_0000, 32'h3f80_0000, RNE, obs, lat, st);
      checks++; if (obs !== {2'b11, QNAN}) begin failures++; $display("FAIL snan got=%h exp=%h", obs, {2'b11, QNAN}); end
      runOne(32'h7fc0_0001, 32'h3f80_0000, 32'h3f80_0000, RNE, obs, lat, st);
      checks++; if (obs !== {2'b10, QNAN}) begin failures++; $display("FAIL qnan got=%h exp=%h", obs, {2'b10, QNAN}); end
   endtask

   task automatic test_denormal();
      logic [33:0] obs, exp; int lat; logic st;
      exp = FLUSH ? {2'b10, 32'h0} : 34'h0;
      runOne(32'h0000_0001, 32'h3f80_0000, 32'h0000_0000, RNE, obs, lat, st);
      checks++; if (obs !== exp) begin failures++; $display("FAIL denormal got=%h exp=%h", obs, exp); end
      // zero product plus denormal C
      exp = refModel(32'h0, 32'h3f80_0000, 32'h8000_0003, RNE);
      runOne(32'h0000_0000, 32'h3f80_0000, 32'h8000_0003, RNE, obs, lat, st);
      checks++; if (obs !== exp) begin failures++; $display("FAIL denormal_c got=%h exp=%h", obs, exp); end
   endtask

   task automatic test_back_pressure();
      logic [31:0] av [4] = '{32'h7f80_0000, 32'h7f80_0000, 32'h7fc0_0000, 32'h0000_0000};
      logic [31:0] bv [4] = '{32'h0000_0000, 32'h3f80_0000, 32'h3f80_0000, 32'h4000_0000};
      logic [31:0] cv [4] = '{32'h3f80_0000, 32'h3f80_0000, 32'h3f80_0000, 32'hc040_0000};
      logic [33:0] q [$];
      logic [33:0] exp, prevDat;
      logic prevVld, prevRdy;
      int sent, got;
      sent = 0; got = 0; prevVld = 1'b0; prevRdy = 1'b1; prevDat = '0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk_i);
         ready_i = (cyc >= 3);
         if (sent < 4) begin valid_i = 1'b1; driveSet(av[sent], bv[sent], cv[sent], RNE); end
         else valid_i = 1'b0;
         #1;
         if (cyc == 2) begin
            checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", ready_o); end
         end
         if (prevVld && !prevRdy) begin
            checks++;
            if (valid_o !== 1'b1 || {special_o, nv_o, result_o} !== prevDat) begin
               failures++; $display("FAIL bp_hold got=%b/%h exp=1/%h", valid_o, {special_o, nv_o, result_o}, prevDat);
            end
         end
         if (valid_i && ready_o) begin q.push_back(refModel(av[sent], bv[sent], cv[sent], RNE)); sent++; end
         if (valid_o && ready_i) begin
            exp = (q.size() > 0) ? q.pop_front() : 34'h3_ffff_ffff;
            got++;
            checks++;
            if ({special_o, nv_o, result_o} !== exp) begin
               failures++; $display("FAIL bp_order_%0d got=%h exp=%h", got, {special_o, nv_o, result_o}, exp);
            end
         end
         prevVld = valid_o; prevRdy = ready_i; prevDat = {special_o, nv_o, result_o};
      end
      valid_i = 1'b0;
      checks++; if (got !== 4 || q.size() != 0) begin failures++; $display("FAIL bp_count got=%0d exp=4", got); end
   endtask

   task automatic test_random();
      logic [33:0] q [$];
      logic [33:0] exp, prevDat;
      logic [31:0] a, b, c;
      logic [2:0]  rm;
      logic prevVld, prevRdy;
      int seen;
      prevVld = 1'b0; prevRdy = 1'b1; prevDat = '0; seen = 0;
      for (int cyc = 0; cyc < 420; cyc++) begin
         @(negedge clk_i);
         a = pickOperand(); b = pickOperand(); c = pickOperand();
         rm = 3'($urandom_range(0, 4));
         driveSet(a, b, c, rm);
         valid_i = (cyc < 400) && ($urandom_range(0, 3) != 0);
         ready_i = (cyc >= 400) || ($urandom_range(0, 3) != 0);
         #1;
         if (prevVld && !prevRdy) begin
            checks++;
            if (valid_o !== 1'b1 || {special_o, nv_o, result_o} !== prevDat) begin
               failures++; $display("FAIL rnd_hold cyc=%0d got=%b/%h exp=1/%h", cyc, valid_o, {special_o, nv_o, result_o}, prevDat);
            end
         end
         if (valid_i && ready_o) q.push_back(refModel(a, b, c, rm));
         if (valid_o && ready_i) begin
            exp = (q.size() > 0) ? q.pop_front() : 34'h3_ffff_ffff;
            seen++;
            checks++;
            if ({special_o, nv_o, result_o} !== exp) begin
               failures++; $display("FAIL rnd_result cyc=%0d got=%h exp=%h", cyc, {special_o, nv_o, result_o}, exp);
            end
         end
         prevVld = valid_o; prevRdy = ready_i; prevDat = {special_o, nv_o, result_o};
      end
      valid_i = 1'b0;
      checks++; if (q.size() != 0 || seen == 0) begin failures++; $display("FAIL rnd_drain got=%0d exp=0 (seen %0d)", q.size(), seen); end
   endtask

   task automatic test_midstream_reset();
      logic [33:0] obs; int lat; logic st; logic anyVld;
      runOne(32'h7f80_0000, 32'h0000_0000, 32'h0000_0000, RNE, obs, lat, st);
      @(negedge clk_i);
      driveSet(32'h7f80_0000, 32'h0000_0000, 32'h3f80_0000, RNE);
      valid_i = 1'b1; ready_i = 1'b1;
      @(negedge clk_i);
      driveSet(32'h3f80_0000, 32'h0000_0000, 32'h3f80_0000, RNE);
      @(negedge clk_i);
      #1;
      checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", valid_o); end
      rst_n_i = 1'b0; valid_i = 1'b0;
      @(posedge clk_i); #1;
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", valid_o); end
      checks++; if (nv_sticky_o !== 1'b0) begin failures++; $display("FAIL mid_rst_sticky got=%b exp=0", nv_sticky_o); end
      @(negedge clk_i); rst_n_i = 1'b1;
      anyVld = 1'b0;
      repeat (4) begin @(posedge clk_i); #1; anyVld |= valid_o; end
      checks++; if (anyVld !== 1'b0) begin failures++; $display("FAIL mid_flush got=%b exp=0", anyVld); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_inf_times_zero();
      test_sticky();
      test_inf_add();
      test_zero_signs();
      test_nan();
      test_denormal();
      test_back_pressure();
      test_random();
      test_midstream_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fma_special_case_handler.md
# fma_special_case_handler

Pipelined stage directly downstream of the operand special-case detector in the FMA datapath. Consumes the per-operand Inf/Zero/NaN/DeN flags plus the raw operands for R = A*B + C and resolves IEEE-754/RISC-V special results: canonical NaN, signed infinities, exact zeros, and C-passthrough. It also raises the invalid-operation (NV) flag. For operand sets that are not special, it tells the normal multiply-add path to supply the result. Elastic valid/ready handshake, 2-cycle latency, sticky NV accumulator.

## Interface
- PARM_XLEN, 32, operand/result width
- PARM_EXP, 8, exponent width
- PARM_MANT, 23, mantissa width
- PARM_CANONICAL_NAN, 32'h7fc0_0000, RISC-V canonical quiet NaN
- clk_i  in  1  clock; single clock domain
- rst_n_i  in  1  reset; synchronous, active-low
- valid_i  in  1  upstream operand set valid
- ready_o  out  1  block can accept an operand set this cycle
- A_i, B_i, C_i  in  PARM_XLEN each  raw operands; sign bit and quiet bit (mantissa MSB) are used
- A/B/C_Inf_i, A/B/C_Zero_i, A/B/C_NaN_i, A/B/C_DeN_i  in  1 each  detector flags
- rm_i  in  3  rounding mode; only RDN (3'b010) is significant
- valid_o  out  1  result set valid
- ready_i  in  1  downstream accepts
- special_o  out  1  result_o overrides the normal path
- result_o  out  PARM_XLEN  special result; 0 when special_o=0
- nv_o  out  1  per-operation invalid flag
- nv_sticky_o  out  1  OR of every nv_o accepted downstream since the last clear
- nv_clear_i  in  1  clears nv_sticky_o

## Operation
- Product sign: Ps = A_sign ^ B_sign. Product is Inf if A or B is Inf. Product is Zero if A or B is Zero.
- Priority order; the first matching rule wins:
  1. Any NaN: special, result = canonical NaN. nv = 1 if any NaN operand has quiet bit 0 (sNaN).
  2. Inf*0 (A Inf and B Zero, or B Inf and A Zero): special, canonical NaN, nv = 1.
  3. Product Inf and C Inf with Ps != C_sign: special, canonical NaN, nv = 1.
  4. Product Inf: special, result = {Ps, exp all-ones, mant 0}.
  5. C Inf: special, result = {C_sign, exp all-ones, mant 0}.
  6. Product Zero and C Zero: special, signed zero. Sign = Ps & C_sign if the signs are equal; otherwise sign = (rm_i == RDN).
  7. Product Zero and C nonzero finite: special, result = C_i unchanged.
  8. Anything else: special_o = 0, result_o = 0, nv = 0.
- Stage 1 registers operands, flags and rm_i, then decodes the rule. Stage 2 registers special_o, result_o and nv_o.
- nv_sticky_o sets on the cycle a transfer with nv_o = 1 completes (valid_o & ready_i). When nv_clear_i is active in that same cycle, set wins.

## Timing
- Reset values: valid_o = 0, special_o = 0, result_o = 0, nv_o = 0, nv_sticky_o = 0, all internal stage valids = 0. ready_o is 1 in the first cycle after reset.
- Latency is 2 cycles from an accepted input (valid_i & ready_o) to valid_o when there is no back-pressure. Throughput is 1 per cycle.
- A stage advances when its successor is empty or is advancing itself. ready_o = ~s1_valid | s1_adv. It is combinational from ready_i; no skid buffer.
- While valid_o is high and ready_i is low, valid_o, special_o, result_o and nv_o hold stable.
- Reset mid-operation flushes both stages with no output. The sticky flag clears too.
- Inputs are sampled only on an accepted transfer. Input values while valid_i is low are don't-care.

## Configuration
- FMA_DENORMAL_FLUSH_EN defined: a DeN operand is treated as a signed Zero (flush-to-zero) before the rule evaluation. Example: A = DeN and C = +0 resolves to a zero result through rule 6.
- FMA_DENORMAL_FLUSH_EN not defined: DeN flags are ignored. Denormals are finite nonzero values and fall to rule 7 or rule 8.

## Structure
- Shared package fma_pkg holds:
  - the rounding-mode localparams (RNE/RTZ/RDN/RUP/RMM)
  - the canonical NaN constant
  - the Inf constant builder
  - the packed operand-class struct {sign, inf, zero, nan, den, quiet}
- One sub-module: fma_special_decode. It is combinational and holds rules 1–8. It is instantiated between the stage-1 and stage-2 registers.

## Test plan
- A = 7f800000 (+Inf), B = 00000000, C = 3f800000, ready_i = 1: two cycles later valid_o = 1, special_o = 1, result_o = 7fc00000, nv_o = 1, and nv_sticky_o is 1 on the following cycle.
- A = 7f800000, B = 3f800000, C = ff800000: result_o = 7fc00000, nv_o = 1. Then with C = 7f800000: result_o = 7f800000, nv_o = 0.
- A = 80000000, B = 3f800000, C = 00000000: with rm = RNE, result_o = 00000000; with rm = RDN, result_o = 80000000. With C = 80000000, result_o = 80000000 in both modes.
- A = 7f800001 (sNaN), B = C = 3f800000: result_o = 7fc00000, nv_o = 1. With A = 7fc00001 (qNaN): nv_o = 0.
- Back-pressure: stream 4 sets while ready_i = 0 for 3 cycles. ready_o drops once both stages are full, valid_o and result_o hold stable, and all 4 results arrive in order with none lost or duplicated.
- A = 00000001 (DeN), B = 3f800000, C = 00000000: with FMA_DENORMAL_FLUSH_EN, special_o = 1 and result_o = 00000000. Without it, special_o = 0. Also assert rst_n_i mid-stream: valid_o goes to 0 next cycle.
